// File: rtl/lamp_handball_pkg.sv
// Shared state and winner encodings for the lamp-handball game.
package lamp_handball_pkg;

   typedef enum logic [2:0] {
      IDLE,
      MOVE_R,
      MOVE_L,
      POINT,
      GAME_OVER
   } state_t;

   localparam logic [1:0] WINNER_NONE  = 2'b00;
   localparam logic [1:0] WINNER_LEFT  = 2'b01;
   localparam logic [1:0] WINNER_RIGHT = 2'b10;

endpackage

// File: rtl/lamp_handball_game_edge_detect.sv
// Single-bit rising-edge detector; a held level fires only on the first cycle.
module hb_edge_detect (
   input  logic clk,
   input  logic reset_n,
   input  logic i_level,
   output logic o_rise
);

   logic r_prev;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_prev <= 1'b0;
      else          r_prev <= i_level;
   end

   assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/lamp_handball_game.sv
// Lamp-handball game: a single lit lamp bounces between two players who return it
// by pressing on their end lamp; misses and early presses score for the opponent.
module lamp_handball_game
   import lamp_handball_pkg::*;
#(
   parameter int N_LAMPS   = 8,
   parameter int TICK_DIV  = 4,
   parameter int SCORE_W   = 4,
   parameter int WIN_SCORE = 9
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic               btn_l,
   input  logic               btn_r,
   output logic [N_LAMPS-1:0] lamp,
   output logic [SCORE_W-1:0] score_l,
   output logic [SCORE_W-1:0] score_r,
   output logic [1:0]         winner
);

   localparam int POS_W  = $clog2(N_LAMPS);
   localparam int TICK_W = $clog2(TICK_DIV) + 1;
   localparam logic [POS_W-1:0]   LAST_POS  = POS_W'(N_LAMPS - 1);
   localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICK_DIV - 1);
   localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_SCORE);
   localparam logic [N_LAMPS-1:0] LEFT_HALF = {N_LAMPS{1'b1}} >> (N_LAMPS - N_LAMPS / 2);

   state_t              r_state;
   logic [POS_W-1:0]    r_pos;
   logic [TICK_W-1:0]   r_tick;
   logic [SCORE_W-1:0]  r_scoreL;
   logic [SCORE_W-1:0]  r_scoreR;
   logic [1:0]          r_winner;
   logic                r_leftScored;
   logic                w_startRise;
   logic                w_btnLRise;
   logic                w_btnRRise;
   logic                w_tickLast;
   logic [N_LAMPS-1:0]  w_lamp;

   hb_edge_detect u_edgeStart (.clk(clk), .reset_n(reset_n), .i_level(start), .o_rise(w_startRise));
   hb_edge_detect u_edgeBtnL  (.clk(clk), .reset_n(reset_n), .i_level(btn_l), .o_rise(w_btnLRise));
   hb_edge_detect u_edgeBtnR  (.clk(clk), .reset_n(reset_n), .i_level(btn_r), .o_rise(w_btnRRise));

   assign w_tickLast = (r_tick == TICK_LAST);

   // Only the player the ball is heading toward is listened to; a hit outranks a tick.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= IDLE;
         r_pos        <= '0;
         r_tick       <= '0;
         r_scoreL     <= '0;
         r_scoreR     <= '0;
         r_winner     <= WINNER_NONE;
         r_leftScored <= 1'b0;
      end else begin
         case (r_state)
            IDLE, GAME_OVER: begin
               if (w_startRise) begin
                  r_scoreL <= '0;
                  r_scoreR <= '0;
                  r_winner <= WINNER_NONE;
                  r_pos    <= '0;
                  r_tick   <= '0;
                  r_state  <= MOVE_R;
               end
            end
            MOVE_R: begin
               r_tick <= (w_btnRRise || w_tickLast) ? '0 : r_tick + 1'b1;
               if (w_btnRRise && r_pos == LAST_POS) begin
                  r_state <= MOVE_L;
               end else if (w_btnRRise || (w_tickLast && r_pos == LAST_POS)) begin
                  r_state      <= POINT;
                  r_leftScored <= 1'b1;
                  if (r_scoreL != WIN) r_scoreL <= r_scoreL + 1'b1;
               end else if (w_tickLast) begin
                  r_pos <= r_pos + 1'b1;
               end
            end
            MOVE_L: begin
               r_tick <= (w_btnLRise || w_tickLast) ? '0 : r_tick + 1'b1;
               if (w_btnLRise && r_pos == '0) begin
                  r_state <= MOVE_R;
               end else if (w_btnLRise || (w_tickLast && r_pos == '0)) begin
                  r_state      <= POINT;
                  r_leftScored <= 1'b0;
                  if (r_scoreR != WIN) r_scoreR <= r_scoreR + 1'b1;
               end else if (w_tickLast) begin
                  r_pos <= r_pos - 1'b1;
               end
            end
            POINT: begin
               if (w_tickLast) begin
                  r_tick <= '0;
                  if (r_leftScored && r_scoreL == WIN) begin
                     r_state  <= GAME_OVER;
                     r_winner <= WINNER_LEFT;
                  end else if (!r_leftScored && r_scoreR == WIN) begin
                     r_state  <= GAME_OVER;
                     r_winner <= WINNER_RIGHT;
                  end else if (r_leftScored) begin
                     r_pos   <= LAST_POS;
                     r_state <= MOVE_L;
                  end else begin
                     r_pos   <= '0;
                     r_state <= MOVE_R;
                  end
               end else begin
                  r_tick <= r_tick + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_comb begin
      w_lamp = '0;
      case (r_state)
         MOVE_R, MOVE_L: w_lamp[r_pos] = 1'b1;
         GAME_OVER:      w_lamp = (r_winner == WINNER_LEFT) ? LEFT_HALF : ~LEFT_HALF;
         default:        w_lamp = '0;
      endcase
   end

   assign lamp    = w_lamp;
   assign score_l = r_scoreL;
   assign score_r = r_scoreR;
   assign winner  = r_winner;

endmodule
